// File: rtl/sram_word_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit async SRAM word sequencer.
package sram_word_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRecover
    } state_e;

    localparam int unsigned HalfWidth     = 16;
    localparam int unsigned WordWidth     = 32;
    localparam int unsigned SramAddrWidth = 18;

    localparam int unsigned SetupCycles   = 1;
    localparam int unsigned RecoverCycles = 1;
    localparam int unsigned MaxWaitCycles = 7;
    localparam int unsigned CntWidth      = 3;

    function automatic logic [HalfWidth-1:0] sel_half(input logic [WordWidth-1:0] word,
                                                       input logic half);
        return half ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/sram_word_ctrl_if.sv
// Command port and SRAM pin bundle; master is the SoC/board side, slave the sequencer.
interface sram_word_ctrl_if;
    import sram_word_ctrl_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [18:0]              cmd_address;
    logic [WordWidth-1:0]     cmd_data;
    logic [3:0]               cmd_mask;
    logic                     rsp_valid;
    logic [WordWidth-1:0]     rsp_data;
    logic [SramAddrWidth-1:0] sram_addr;
    logic [HalfWidth-1:0]     sram_dat_read;
    logic [HalfWidth-1:0]     sram_dat_write;
    logic                     sram_dat_writeEnable;
    logic                     sram_cs;
    logic                     sram_we;
    logic                     sram_oe;
    logic                     sram_lb;
    logic                     sram_ub;

    modport master (
        output cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask, sram_dat_read,
        input  cmd_ready, rsp_valid, rsp_data, sram_addr, sram_dat_write,
               sram_dat_writeEnable, sram_cs, sram_we, sram_oe, sram_lb, sram_ub
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask, sram_dat_read,
        output cmd_ready, rsp_valid, rsp_data, sram_addr, sram_dat_write,
               sram_dat_writeEnable, sram_cs, sram_we, sram_oe, sram_lb, sram_ub
    );

endinterface

// File: rtl/sram_half_timer.sv
// Per-phase down-counter; reloaded on every state change, last is high on the final cycle.
module sram_half_timer
    import sram_word_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [CntWidth-1:0] load_val,
    output logic                last
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/sram_word_ctrl.sv
// Splits 32-bit commands into two timed 16-bit async SRAM cycles, low half first.
module sram_word_ctrl
    import sram_word_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic            io_mainClk,
    input logic            io_asyncResetn,
    sram_word_ctrl_if.slave bus
);

    localparam int unsigned WaitCycles =
        (WAIT_CYCLES > MaxWaitCycles) ? MaxWaitCycles : WAIT_CYCLES;

    state_e                   state_q, state_d;
    logic                     half_q, half_d;
    logic                     write_q, write_d;
    logic [16:0]              addr_q, addr_d;
    logic [WordWidth-1:0]     data_q, data_d;
    logic [3:0]               mask_q, mask_d;
    logic                     ready_q, ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [WordWidth-1:0]     rsp_data_q, rsp_data_d;
    logic [SramAddrWidth-1:0] sram_addr_q, sram_addr_d;
    logic [HalfWidth-1:0]     dat_write_q, dat_write_d;
    logic                     dwe_q, dwe_d;
    logic                     cs_q, cs_d, we_q, we_d, oe_q, oe_d, lb_q, lb_d, ub_q, ub_d;

    logic                     go_setup, go_half;
    logic                     src_write;
    logic [16:0]              src_addr;
    logic [WordWidth-1:0]     src_data;
    logic [3:0]               src_mask;
    logic                     timer_load, timer_last;
    logic [CntWidth-1:0]      timer_val;
    logic                     unused_addr;

    assign unused_addr = ^bus.cmd_address[1:0];

    // The first half is set up straight from the command port; the second from latched copies.
    assign src_write = (state_q == StIdle) ? bus.cmd_write          : write_q;
    assign src_addr  = (state_q == StIdle) ? bus.cmd_address[18:2]  : addr_q;
    assign src_data  = (state_q == StIdle) ? bus.cmd_data           : data_q;
    assign src_mask  = (state_q == StIdle) ? bus.cmd_mask           : mask_q;

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        sram_addr_d = sram_addr_q;
        dat_write_d = dat_write_q;
        dwe_d       = dwe_q;
        cs_d        = cs_q;
        we_d        = we_q;
        oe_d        = oe_q;
        lb_d        = lb_q;
        ub_d        = ub_q;
        go_setup    = 1'b0;
        go_half     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && ready_q) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_address[18:2];
                    data_d  = bus.cmd_data;
                    mask_d  = bus.cmd_mask;
                    if (!bus.cmd_write || (bus.cmd_mask[1:0] != 2'b00)) begin
                        go_setup = 1'b1;
                    end else if (bus.cmd_mask[3:2] != 2'b00) begin
                        go_setup = 1'b1;
                        go_half  = 1'b1;
                    end else begin
                        // Empty write: one busy cycle with pins left idle.
                        state_d = StRecover;
                    end
                end
            end
            StSetup: begin
                if (timer_last) begin
                    state_d = StStrobe;
                    we_d    = ~write_q;
                    oe_d    = write_q;
                end
            end
            StStrobe: begin
                if (timer_last) begin
                    state_d = StRecover;
                    we_d    = 1'b1;
                    oe_d    = 1'b1;
                    if (!write_q) begin
                        if (half_q) data_d[31:16] = bus.sram_dat_read;
                        else        data_d[15:0]  = bus.sram_dat_read;
                    end
                end
            end
            StRecover: begin
                if (timer_last) begin
                    if (!half_q && (!write_q || (mask_q[3:2] != 2'b00))) begin
                        go_setup = 1'b1;
                        go_half  = 1'b1;
                    end else begin
                        state_d = StIdle;
                        cs_d    = 1'b1;
                        dwe_d   = 1'b0;
                        lb_d    = 1'b1;
                        ub_d    = 1'b1;
                        if (!write_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = data_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_setup) begin
            state_d     = StSetup;
            half_d      = go_half;
            cs_d        = 1'b0;
            we_d        = 1'b1;
            oe_d        = 1'b1;
            sram_addr_d = {src_addr, go_half};
            if (src_write) begin
                dat_write_d = sel_half(src_data, go_half);
                dwe_d       = 1'b1;
                lb_d        = ~src_mask[{go_half, 1'b0}];
                ub_d        = ~src_mask[{go_half, 1'b1}];
            end else begin
                dwe_d = 1'b0;
                lb_d  = 1'b0;
                ub_d  = 1'b0;
            end
        end
    end

    assign ready_d    = (state_d == StIdle);
    assign timer_load = (state_d != state_q);

    always_comb begin
        case (state_d)
            StSetup:   timer_val = CntWidth'(SetupCycles - 1);
            StStrobe:  timer_val = CntWidth'(WaitCycles);
            StRecover: timer_val = CntWidth'(RecoverCycles - 1);
            default:   timer_val = '0;
        endcase
    end

    sram_half_timer u_timer (
        .clk      (io_mainClk),
        .rst_n    (io_asyncResetn),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q     <= StIdle;
            half_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sram_addr_q <= '0;
            dat_write_q <= '0;
            dwe_q       <= 1'b0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
            oe_q        <= 1'b1;
            lb_q        <= 1'b1;
            ub_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sram_addr_q <= sram_addr_d;
            dat_write_q <= dat_write_d;
            dwe_q       <= dwe_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            lb_q        <= lb_d;
            ub_q        <= ub_d;
        end
    end

    assign bus.cmd_ready            = ready_q;
    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_data             = rsp_data_q;
    assign bus.sram_addr            = sram_addr_q;
    assign bus.sram_dat_write       = dat_write_q;
    assign bus.sram_dat_writeEnable = dwe_q;
    assign bus.sram_cs              = cs_q;
    assign bus.sram_we              = we_q;
    assign bus.sram_oe              = oe_q;
    assign bus.sram_lb              = lb_q;
    assign bus.sram_ub              = ub_q;

endmodule
